// File: rtl/router_pkg.sv
// Shared router types: input-arbiter state encoding and packet header field layout.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FWD   = 2'b01,
    DRAIN = 2'b10
  } arb_state_t;

  localparam int unsigned HDR_DEST_LSB = 0;
  localparam int unsigned HDR_DEST_W   = 2;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_LEN_W    = 6;
  localparam int unsigned LEN_CNT_W    = 8;

endpackage

// File: rtl/router_rr_sel.sv
// Combinational round-robin picker: first set req bit scanning ptr+1, ptr+2, ... modulo NUM_SRC.
module router_rr_sel #(
  parameter  int unsigned NUM_SRC = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan farthest-first so the nearest requester after ptr is the last (winning) assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_SRC]) begin
        valid = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % NUM_SRC);
      end
    end
  end

endmodule

// File: rtl/router_in_arbiter.sv
// Packet-level round-robin arbiter sharing the router input among NUM_SRC sources.
// Optional payload length check enabled by defining ROUTER_ARB_LEN_CHECK_EN.
module router_in_arbiter
  import router_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 3,
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_SRC-1:0]        src_pkt_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_busy,
  output logic [NUM_SRC-1:0]        src_abort,
  output logic                      rtr_pkt_valid,
  output logic [DATA_W-1:0]         rtr_data,
  input  logic                      rtr_busy,
  input  logic                      rtr_abort,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      len_err
);

  arb_state_t          r_state, w_nxt_state;
  logic [NUM_SRC-1:0]  r_grant, w_nxt_grant;
  logic [IDX_W-1:0]    r_rr_ptr, w_nxt_ptr;
  logic                r_hdr_seen, w_nxt_hdr;
  logic                w_sel_valid;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_g_valid;
  logic [DATA_W-1:0]   w_g_data;

  router_rr_sel #(.NUM_SRC(NUM_SRC)) u_rr_sel (
    .req   (src_pkt_valid),
    .ptr   (r_rr_ptr),
    .valid (w_sel_valid),
    .idx   (w_sel_idx)
  );

  // Granted source's lane, selected by the one-hot grant.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant[i]) begin
        w_g_valid = src_pkt_valid[i];
        w_g_data  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= IDX_W'(NUM_SRC - 1);
      r_hdr_seen <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_grant    <= w_nxt_grant;
      r_rr_ptr   <= w_nxt_ptr;
      r_hdr_seen <= w_nxt_hdr;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_ptr   = r_rr_ptr;
    w_nxt_hdr   = r_hdr_seen;
    case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_nxt_state = FWD;
          w_nxt_grant = NUM_SRC'(1) << w_sel_idx;
          w_nxt_ptr   = w_sel_idx;
          w_nxt_hdr   = 1'b0;
        end
      end
      FWD: begin
        // Abort and a source dropping valid before its header both abandon the packet.
        if (rtr_abort || (!r_hdr_seen && !w_g_valid)) begin
          w_nxt_state = IDLE;
          w_nxt_grant = '0;
          w_nxt_hdr   = 1'b0;
        end else if (!rtr_busy) begin
          if (!r_hdr_seen) begin
            w_nxt_hdr = 1'b1;
          end else if (!w_g_valid) begin
            w_nxt_state = DRAIN;
            w_nxt_hdr   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (rtr_abort || !rtr_busy) begin
          w_nxt_state = IDLE;
          w_nxt_grant = '0;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_grant = '0;
        w_nxt_hdr   = 1'b0;
      end
    endcase
  end

  // Zero-latency output mux driven from registered state and grant.
  always_comb begin
    src_busy      = '1;
    src_abort     = '0;
    rtr_pkt_valid = 1'b0;
    rtr_data      = '0;
    case (r_state)
      FWD: begin
        rtr_pkt_valid = w_g_valid;
        rtr_data      = w_g_data;
        if (!rtr_busy) src_busy = ~r_grant;
        if (rtr_abort) src_abort = r_grant;
      end
      DRAIN: begin
        if (rtr_abort) src_abort = r_grant;
      end
      default: ;
    endcase
  end

  assign grant = r_grant;

`ifdef ROUTER_ARB_LEN_CHECK_EN
  logic                  w_xfer;
  logic                  w_hdr_xfer;
  logic                  w_pay_xfer;
  logic                  w_eop;
  logic [LEN_CNT_W-1:0]  r_pay_cnt;
  logic [HDR_LEN_W-1:0]  r_hdr_len;
  logic                  r_len_err;

  assign w_xfer     = (r_state == FWD) && !rtr_busy && !rtr_abort;
  assign w_hdr_xfer = w_xfer && !r_hdr_seen && w_g_valid;
  assign w_pay_xfer = w_xfer &&  r_hdr_seen && w_g_valid;
  assign w_eop      = w_xfer &&  r_hdr_seen && !w_g_valid;

  // Saturating payload counter compared against the latched header length at end of packet.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pay_cnt <= '0;
      r_hdr_len <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      if (w_hdr_xfer) begin
        r_pay_cnt <= '0;
        r_hdr_len <= w_g_data[HDR_LEN_LSB +: HDR_LEN_W];
      end else if (w_pay_xfer && (r_pay_cnt != '1)) begin
        r_pay_cnt <= r_pay_cnt + LEN_CNT_W'(1);
      end
      if (w_eop) r_len_err <= (r_pay_cnt != LEN_CNT_W'(r_hdr_len));
    end
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

endmodule
